// File: rtl/io_stall_ctrl.sv
// io_stall_ctrl: stalls the CPU on a switch read until the operator confirms,
// then presents the captured switch value for one DONE cycle. Also registers
// LED/seven-segment writes into a held display word with a one-cycle strobe.
// Optional forced release after TIMEOUT_CYCLES wait cycles: define IO_TIMEOUT_EN.
module io_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        io_read_req,
    input  logic        io_write_req,
    input  logic        confirm,
    input  logic [15:0] switches,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        led_we,
    output logic [31:0] led_data,
    output logic        timeout_flag,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t cur;
    state_t nxt;
    logic   capture;
    logic   expire;
    logic   write_ok;
    logic   at_limit;

    assign state = cur;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             tflag;

    assign at_limit     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = tflag;

    // Wait-cycle counter: cleared on entry to WAIT, saturating, never wraps.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cur == IDLE && io_read_req) begin
            cnt <= '0;
        end else if (cur == WAIT && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sticky record of a forced release; only a reset clears it.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            tflag <= 1'b0;
        end else if (expire) begin
            tflag <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign at_limit       = 1'b0;
    assign timeout_flag   = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State register; an illegal encoding falls back to IDLE via nxt.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next state and the combinational stall; confirm wins over expiry.
    always_comb begin
        nxt      = IDLE;
        stall    = 1'b0;
        capture  = 1'b0;
        expire   = 1'b0;
        write_ok = 1'b0;
        case (cur)
            IDLE: begin
                if (io_read_req) begin
                    nxt   = WAIT;
                    stall = 1'b1;
                end else begin
                    write_ok = io_write_req;
                end
            end
            WAIT: begin
                stall = 1'b1;
                nxt   = WAIT;
                if (confirm) begin
                    capture = 1'b1;
                    nxt     = DONE;
                end else if (at_limit) begin
                    expire = 1'b1;
                    nxt    = DONE;
                end
            end
            DONE: begin
                nxt      = IDLE;
                write_ok = io_write_req;
            end
            default: nxt = IDLE;
        endcase
    end

    // Read data path: switch snapshot on confirm, zero on forced release.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rdata       <= 16'h0000;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= (nxt == DONE);
            if (capture) begin
                rdata <= switches;
            end else if (expire) begin
                rdata <= 16'h0000;
            end
        end
    end

    // Display word and its one-cycle update strobe.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            led_data <= 32'h0;
            led_we   <= 1'b0;
        end else begin
            led_we <= write_ok;
            if (write_ok) begin
                led_data <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_io_stall_ctrl.sv
// Bench for io_stall_ctrl: directed stimulus pushes expected read/write
// completions into queues; a negedge monitor pops them when the DUT strobes.
module tb_io_stall_ctrl;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_read_req = 1'b0;
    logic        io_write_req = 1'b0;
    logic        confirm = 1'b0;
    logic [15:0] switches = 16'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        led_we;
    logic [31:0] led_data;
    logic        timeout_flag;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    logic [16:0] e_rd;
    logic [31:0] e_wr;

    io_stall_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .rst_n(rst_n), .io_read_req(io_read_req),
        .io_write_req(io_write_req), .confirm(confirm), .switches(switches),
        .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .led_we(led_we), .led_data(led_data), .timeout_flag(timeout_flag),
        .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Move to the next cycle; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every rdata_valid / led_we strobe must match a queued expectation.
    always @(negedge clock) begin
        if (rst_n) begin
            if (rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=%h required=none", rdata);
                end else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_data", 32'(rdata), 32'(e_rd[15:0]));
                    chk("rd_tflag", 32'(timeout_flag), 32'(e_rd[16]));
                end
            end
            if (led_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%h required=none", led_data);
                end else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_data", led_data, e_wr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rvalid", 32'(rdata_valid), 32'h0);
        chk("rst_led_we", 32'(led_we), 32'h0);
        chk("rst_led_data", led_data, 32'h0);
        chk("rst_tflag", 32'(timeout_flag), 32'h0);
        rst_n = 1'b1;

        // Read stall: request at N, confirm at N+10
        step();
        switches = 16'hA5C3; io_read_req = 1'b1; #1;
        chk("rs_stall_n", 32'(stall), 32'h1);
        chk("rs_state_n", 32'(state), 32'h0);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 10) begin
                confirm = 1'b1;
                exp_rd.push_back({1'b0, 16'hA5C3});
            end
            #1;
            chk("rs_stall_w", 32'(stall), 32'h1);
            chk("rs_state_w", 32'(state), 32'h1);
        end
        step(); confirm = 1'b0; #1;
        chk("rs_state_done", 32'(state), 32'h2);
        chk("rs_stall_done", 32'(stall), 32'h0);
        step(); io_read_req = 1'b0; #1;
        chk("rs_state_idle", 32'(state), 32'h0);
        chk("rs_rdata_hold", 32'(rdata), 32'hA5C3);

        // Early confirm in IDLE, and one coincident with the request
        step(); confirm = 1'b1; switches = 16'hFFFF; #1;
        chk("ec_state", 32'(state), 32'h0);
        step(); confirm = 1'b0;
        step();
        step(); io_read_req = 1'b1; confirm = 1'b1; #1;
        chk("ec_stall", 32'(stall), 32'h1);
        step(); confirm = 1'b0; #1;
        chk("ec_wait", 32'(state), 32'h1);
        step();
        step(); switches = 16'h0F0F; confirm = 1'b1;
        exp_rd.push_back({1'b0, 16'h0F0F});
        step(); confirm = 1'b0; io_read_req = 1'b0; #1;
        chk("ec_done", 32'(state), 32'h2);
        step(); #1;
        chk("ec_idle", 32'(state), 32'h0);
        chk("ec_rdata", 32'(rdata), 32'h0F0F);

        // Write path
        step(); io_write_req = 1'b1; wdata = 32'h1234_5678;
        exp_wr.push_back(32'h1234_5678);
        step(); io_write_req = 1'b0; #1;
        chk("wr_led_data", led_data, 32'h1234_5678);
        step(); #1;
        chk("wr_we_once", 32'(led_we), 32'h0);

        // Read+write together (read wins), writes in WAIT dropped
        step(); io_read_req = 1'b1; io_write_req = 1'b1; wdata = 32'hCAFE_F00D;
        step(); wdata = 32'hDEAD_BEEF;
        step(); #1;
        chk("wr_wait_state", 32'(state), 32'h1);
        chk("wr_wait_drop", led_data, 32'h1234_5678);
        step(); io_write_req = 1'b0; switches = 16'h1111; confirm = 1'b1;
        exp_rd.push_back({1'b0, 16'h1111});
        // DONE: request still high (ignored), write accepted
        step(); confirm = 1'b0; io_write_req = 1'b1; wdata = 32'h55AA_55AA;
        exp_wr.push_back(32'h55AA_55AA);
        #1;
        chk("b2b_done", 32'(state), 32'h2);
        // Back-to-back read stalls again right after DONE
        step(); io_write_req = 1'b0; #1;
        chk("b2b_idle", 32'(state), 32'h0);
        chk("b2b_stall", 32'(stall), 32'h1);
        chk("done_write", led_data, 32'h55AA_55AA);
        step(); #1;
        chk("b2b_wait", 32'(state), 32'h1);
        switches = 16'h2222; confirm = 1'b1;
        exp_rd.push_back({1'b0, 16'h2222});
        step(); confirm = 1'b0; io_read_req = 1'b0;
        step(); #1;
        chk("b2b_end", 32'(state), 32'h0);

        // Reset mid-WAIT
        step(); io_read_req = 1'b1;
        step(); io_read_req = 1'b0; #1;
        chk("rw_wait", 32'(state), 32'h1);
        chk("rw_stall", 32'(stall), 32'h1);
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        chk("rw_state", 32'(state), 32'h0);
        chk("rw_stall0", 32'(stall), 32'h0);
        chk("rw_rdata", 32'(rdata), 32'h0);
        chk("rw_led", led_data, 32'h0);
        step(); confirm = 1'b1; switches = 16'h3333;
        step(); confirm = 1'b0; #1;
        chk("rw_conf_state", 32'(state), 32'h0);
        chk("rw_conf_rdata", 32'(rdata), 32'h0);

`ifdef IO_TIMEOUT_EN
        // Minimum stall read so rdata is non-zero before the timeout
        step(); io_read_req = 1'b1; switches = 16'h7777;
        step(); confirm = 1'b1; exp_rd.push_back({1'b0, 16'h7777});
        step(); confirm = 1'b0; io_read_req = 1'b0;
        step();
        // Timeout: request at 0, WAIT 1..8, DONE at 9 with zero data
        step(); io_read_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(); io_read_req = 1'b0;
            if (i == 8) exp_rd.push_back({1'b1, 16'h0000});
            #1;
            chk("to_wait", 32'(state), 32'h1);
        end
        step(); #1;
        chk("to_done", 32'(state), 32'h2);
        repeat (3) step();
        chk("to_flag_held", 32'(timeout_flag), 32'h1);
        chk("to_rdata", 32'(rdata), 32'h0);
        // Tie: confirm coincident with expiry wins
        rst_n = 1'b0;
        step(); rst_n = 1'b1;
        step(); io_read_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(); io_read_req = 1'b0;
            if (i == 8) begin
                switches = 16'h1357; confirm = 1'b1;
                exp_rd.push_back({1'b0, 16'h1357});
            end
        end
        step(); confirm = 1'b0; #1;
        chk("tie_done", 32'(state), 32'h2);
        step(); #1;
        chk("tie_flag", 32'(timeout_flag), 32'h0);
        chk("tie_rdata", 32'(rdata), 32'h1357);
`else
        // Without the timeout, WAIT persists indefinitely
        step(); io_read_req = 1'b1;
        repeat (20) step();
        io_read_req = 1'b0; #1;
        chk("nt_wait", 32'(state), 32'h1);
        chk("nt_flag", 32'(timeout_flag), 32'h0);
        switches = 16'h4444; confirm = 1'b1;
        exp_rd.push_back({1'b0, 16'h4444});
        step(); confirm = 1'b0; #1;
        chk("nt_done", 32'(state), 32'h2);
`endif

        repeat (3) step();
        chk("sb_rd_drain", 32'(exp_rd.size()), 32'h0);
        chk("sb_wr_drain", 32'(exp_wr.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
